// File: rtl/ifm_conv_addr_gen_pkg.sv
// Shared types and elaboration-time geometry helpers for the IFM convolution
// address generator.
package ifm_conv_addr_gen_pkg;

  // Width of each nested window counter (kx/ky/c/ox/oy).
  localparam int CNT_W  = 16;
  // Width of the signed coordinate/base arithmetic.
  localparam int BASE_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Output feature map edge O = (W + 2P - K)/S + 1.
  function automatic int ofm_size(input int w, input int k, input int s, input int p);
    return (w + 2 * p - k) / s + 1;
  endfunction

  // Beats in one full frame sweep: O*O*C*K*K.
  function automatic int frame_beats(input int o, input int c, input int k);
    return o * o * c * k * k;
  endfunction

  // Words in one channel plane: W*W.
  function automatic int plane_size(input int w);
    return w * w;
  endfunction

endpackage

// File: rtl/ifm_conv_addr_gen_window_counter.sv
// Nested kx/ky/c/ox/oy sweep counters with per-level wrap and frame-last flags.
module ifm_window_counter
  import ifm_conv_addr_gen_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int OFM_SIZE    = 26,
  parameter int IFM_CHANNEL = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             advance,
  output logic [CNT_W-1:0] kx,
  output logic [CNT_W-1:0] ky,
  output logic             wrap_kx,
  output logic             wrap_ky,
  output logic             wrap_c,
  output logic             wrap_ox,
  output logic             last
);

  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(KERNEL_SIZE - 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(IFM_CHANNEL - 1);
  localparam logic [CNT_W-1:0] O_MAX = CNT_W'(OFM_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] ch;
  logic [CNT_W-1:0] ox;
  logic [CNT_W-1:0] oy;

  // Each level wraps only when every inner level is also at its limit.
  always_comb begin
    wrap_kx = (kx == K_MAX);
    wrap_ky = wrap_kx && (ky == K_MAX);
    wrap_c  = wrap_ky && (ch == C_MAX);
    wrap_ox = wrap_c && (ox == O_MAX);
    last    = wrap_ox && (oy == O_MAX);
  end

  // Counters step once per accepted beat; clear restarts the sweep at beat 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
      ch <= '0;
      ox <= '0;
      oy <= '0;
    end else if (clear) begin
      kx <= '0;
      ky <= '0;
      ch <= '0;
      ox <= '0;
      oy <= '0;
    end else if (advance) begin
      kx <= wrap_kx ? '0 : kx + ONE;
      if (wrap_kx) ky <= wrap_ky ? '0 : ky + ONE;
      if (wrap_ky) ch <= wrap_c ? '0 : ch + ONE;
      if (wrap_c)  ox <= wrap_ox ? '0 : ox + ONE;
      if (wrap_ox) oy <= last ? '0 : oy + ONE;
    end
  end

endmodule

// File: rtl/ifm_conv_addr_gen.sv
// IFM SRAM address generator for a KxK convolution sweep with stride and
// zero padding; one beat per cycle under a valid/ready handshake.
module ifm_conv_addr_gen
  import ifm_conv_addr_gen_pkg::*;
#(
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int PADDING     = 1,
  parameter int IFM_SIZE    = 26,
  parameter int IFM_CHANNEL = 20,
  parameter int ADDR_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  addr_ready,
  output logic [ADDR_WIDTH-1:0] ifm_addr,
  output logic                  addr_valid,
  output logic                  pad,
  output logic                  read_en,
  output logic                  last,
  output logic                  busy,
  output logic                  done
);

  localparam int OFM = ofm_size(IFM_SIZE, KERNEL_SIZE, STRIDE, PADDING);

  localparam logic signed [BASE_W-1:0] NEG_P      = BASE_W'(-PADDING);
  localparam logic signed [BASE_W-1:0] NEG_PW     = BASE_W'(-(PADDING * IFM_SIZE));
  localparam logic signed [BASE_W-1:0] S_STEP     = BASE_W'(STRIDE);
  localparam logic signed [BASE_W-1:0] ROW_STEP   = BASE_W'(STRIDE * IFM_SIZE);
  localparam logic signed [BASE_W-1:0] W_STEP     = BASE_W'(IFM_SIZE);
  localparam logic signed [BASE_W-1:0] PLANE_STEP = BASE_W'(plane_size(IFM_SIZE));

  state_t state;
  state_t state_next;

  logic             launch;
  logic             accept;
  logic [CNT_W-1:0] kx;
  logic [CNT_W-1:0] ky;
  logic             wrap_kx;
  logic             wrap_ky;
  logic             wrap_c;
  logic             wrap_ox;
  logic             last_beat;

  // oy_base/ox_base are oy*S-P and ox*S-P; oy_row is oy_base*W, ky_row is
  // ky*W and c_base is c*W*W, all stepped by constants so the beat path
  // needs only adders.
  logic signed [BASE_W-1:0] oy_base;
  logic signed [BASE_W-1:0] ox_base;
  logic signed [BASE_W-1:0] oy_row;
  logic signed [BASE_W-1:0] ky_row;
  logic signed [BASE_W-1:0] c_base;
  logic signed [BASE_W-1:0] iy;
  logic signed [BASE_W-1:0] ix;
  logic signed [BASE_W-1:0] addr_full;
  logic                     pad_raw;

  assign launch = (state == ST_IDLE) && start;
  assign accept = addr_valid && addr_ready;

  ifm_window_counter #(
    .KERNEL_SIZE (KERNEL_SIZE),
    .OFM_SIZE    (OFM),
    .IFM_CHANNEL (IFM_CHANNEL)
  ) u_window_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (launch),
    .advance (accept),
    .kx      (kx),
    .ky      (ky),
    .wrap_kx (wrap_kx),
    .wrap_ky (wrap_ky),
    .wrap_c  (wrap_c),
    .wrap_ox (wrap_ox),
    .last    (last_beat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: start only honoured in IDLE, DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (accept && last_beat) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and beat outputs; everything is gated to zero outside RUN.
  always_comb begin
    addr_valid = (state == ST_RUN);
    busy       = (state == ST_RUN);
    done       = (state == ST_DONE);
    pad        = addr_valid && pad_raw;
    last       = addr_valid && last_beat;
    read_en    = addr_valid && addr_ready && !pad_raw;
    ifm_addr   = (addr_valid && !pad_raw) ? ADDR_WIDTH'(addr_full) : '0;
  end

  // Signed input coordinates, border test and channel/row-major address.
  always_comb begin
    iy        = oy_base + $signed(BASE_W'(ky));
    ix        = ox_base + $signed(BASE_W'(kx));
    pad_raw   = (iy < 0) || (iy >= W_STEP) || (ix < 0) || (ix >= W_STEP);
    addr_full = c_base + oy_row + ky_row + ix;
  end

  // Incremental bases follow the same wrap flags as the counters so they
  // always describe the beat currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oy_base <= '0;
      ox_base <= '0;
      oy_row  <= '0;
      ky_row  <= '0;
      c_base  <= '0;
    end else if (launch) begin
      oy_base <= NEG_P;
      ox_base <= NEG_P;
      oy_row  <= NEG_PW;
      ky_row  <= '0;
      c_base  <= '0;
    end else if (accept) begin
      if (wrap_ky)      ky_row <= '0;
      else if (wrap_kx) ky_row <= ky_row + W_STEP;
      if (wrap_c)       c_base <= '0;
      else if (wrap_ky) c_base <= c_base + PLANE_STEP;
      if (wrap_ox)      ox_base <= NEG_P;
      else if (wrap_c)  ox_base <= ox_base + S_STEP;
      if (wrap_ox) begin
        oy_base <= oy_base + S_STEP;
        oy_row  <= oy_row + ROW_STEP;
      end
    end
  end

endmodule

// File: tb/tb_ifm_conv_addr_gen.sv
// Scoreboard bench for ifm_conv_addr_gen: three configurations, queued
// expected beats, decoupled monitor, stalls, ignored start and mid-sweep reset.
module tb_ifm_conv_addr_gen;

  localparam int AW = 14;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          pad;
    logic          lst;
  } beat_t;

  typedef struct packed {
    int sel;
    int beat;
    int addr;
    int pad;
    int lst;
  } spot_t;

  logic                   clk;
  logic                   rst_n;
  logic [2:0]             start;
  logic                   ready;
  logic [2:0][AW-1:0]     addr_v;
  logic [2:0]             valid_v, pad_v, rd_v, last_v, busy_v, done_v;

  logic [1:0]    sel;
  logic [AW-1:0] m_addr;
  logic          m_valid, m_pad, m_rd, m_last, m_busy, m_done;

  beat_t exp_q[$];
  int    checks, errors;
  int    beat_idx, frames_done, frame_len, done_phase;
  logic  rand_mode;
  logic  stall_prev;
  beat_t stall_val;

  // Hand-computed spot values: {config, beat, addr, pad, last}.
  spot_t spots [24] = '{
    '{0, 0, 0, 1, 0}, '{0, 3, 0, 1, 0}, '{0, 4, 0, 0, 0}, '{0, 5, 1, 0, 0},
    '{0, 7, 4, 0, 0}, '{0, 9, 0, 1, 0}, '{0, 13, 16, 0, 0}, '{0, 286, 0, 1, 0},
    '{0, 287, 0, 1, 1},
    '{1, 0, 0, 0, 0}, '{1, 1, 676, 0, 0}, '{1, 20, 1, 0, 0}, '{1, 13519, 13519, 0, 1},
    '{2, 0, 0, 0, 0}, '{2, 1, 1, 0, 0}, '{2, 2, 2, 0, 0}, '{2, 3, 5, 0, 0},
    '{2, 4, 6, 0, 0}, '{2, 5, 7, 0, 0}, '{2, 6, 10, 0, 0}, '{2, 7, 11, 0, 0},
    '{2, 8, 12, 0, 0}, '{2, 9, 2, 0, 0}, '{2, 35, 24, 0, 1}
  };

  ifm_conv_addr_gen #(
    .KERNEL_SIZE(3), .STRIDE(1), .PADDING(1), .IFM_SIZE(4), .IFM_CHANNEL(2), .ADDR_WIDTH(AW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr_ready(ready),
    .ifm_addr(addr_v[0]), .addr_valid(valid_v[0]), .pad(pad_v[0]), .read_en(rd_v[0]),
    .last(last_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  ifm_conv_addr_gen #(
    .KERNEL_SIZE(1), .STRIDE(1), .PADDING(0), .IFM_SIZE(26), .IFM_CHANNEL(20), .ADDR_WIDTH(AW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr_ready(ready),
    .ifm_addr(addr_v[1]), .addr_valid(valid_v[1]), .pad(pad_v[1]), .read_en(rd_v[1]),
    .last(last_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  ifm_conv_addr_gen #(
    .KERNEL_SIZE(3), .STRIDE(2), .PADDING(0), .IFM_SIZE(5), .IFM_CHANNEL(1), .ADDR_WIDTH(AW)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .addr_ready(ready),
    .ifm_addr(addr_v[2]), .addr_valid(valid_v[2]), .pad(pad_v[2]), .read_en(rd_v[2]),
    .last(last_v[2]), .busy(busy_v[2]), .done(done_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    m_addr  = addr_v[sel];
    m_valid = valid_v[sel];
    m_pad   = pad_v[sel];
    m_rd    = rd_v[sel];
    m_last  = last_v[sel];
    m_busy  = busy_v[sel];
    m_done  = done_v[sel];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d beat=%0d got=%0h want=%0h", name, sel, beat_idx, act, exp);
    end
  endtask

  // Reference model: direct nested loops with explicit multiplies.
  task automatic push_frame(input int k, input int s, input int p, input int w, input int c);
    int o, total, n, iy, ix;
    beat_t b;
    o = (w + 2 * p - k) / s + 1;
    total = o * o * c * k * k;
    n = 0;
    for (int oy = 0; oy < o; oy++)
      for (int ox = 0; ox < o; ox++)
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              iy = oy * s + ky - p;
              ix = ox * s + kx - p;
              b.pad  = (iy < 0) || (iy >= w) || (ix < 0) || (ix >= w);
              b.addr = b.pad ? '0 : AW'(ch * w * w + iy * w + ix);
              b.lst  = (n == total - 1);
              exp_q.push_back(b);
              n++;
            end
  endtask

  // Ready pattern: constant high or random toggling.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every accepted beat, checks stalls and done.
  always @(negedge clk) begin
    beat_t got, want;
    if (!rst_n) begin
      stall_prev = 1'b0;
      done_phase = 0;
    end else if (done_phase == 1) begin
      check("done_pulse", 32'({m_done, m_valid}), 32'b10);
      done_phase = 2;
    end else if (done_phase == 2) begin
      check("done_clear", 32'({m_done, m_busy, m_valid}), 32'b000);
      done_phase = 0;
      frames_done++;
    end else if (m_valid) begin
      got = {m_addr, m_pad, m_last};
      check("read_en", 32'(m_rd), 32'(ready & ~m_pad));
      if (!ready) begin
        if (stall_prev) check("stall_hold", 32'(got), 32'(stall_val));
        stall_prev = 1'b1;
        stall_val  = got;
      end else begin
        stall_prev = 1'b0;
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("beat", 32'(got), 32'(want));
        end
        for (int i = 0; i < 24; i++)
          if (spots[i].sel == int'(sel) && spots[i].beat == beat_idx)
            check("spot", 32'(got),
                  32'({spots[i].addr[AW-1:0], spots[i].pad[0], spots[i].lst[0]}));
        if (sel == 2'd1)
          check("k1_formula", 32'(m_addr), 32'((beat_idx % 20) * 676 + beat_idx / 20));
        if (m_last) begin
          check("frame_len", 32'(beat_idx + 1), 32'(frame_len));
          done_phase = 1;
        end
        beat_idx++;
      end
    end else begin
      check("idle_read_en", 32'(m_rd), 32'(0));
    end
  end

  task automatic pulse_start(input int idx);
    @(posedge clk);
    #1 start[idx] = 1'b1;
    @(posedge clk);
    #1 start[idx] = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    for (int cyc = 0; cyc < 4000 && beat_idx < n; cyc++) @(posedge clk);
    if (beat_idx < n) check("wait_beats_timeout", 32'(beat_idx), 32'(n));
  endtask

  task automatic run_frame(input int idx, input int k, input int s, input int p,
                           input int w, input int c, input logic rr, input int total);
    int fd0;
    sel       = 2'(idx);
    beat_idx  = 0;
    frame_len = total;
    rand_mode = rr;
    exp_q.delete();
    push_frame(k, s, p, w, c);
    fd0 = frames_done;
    pulse_start(idx);
    #4 check("first_valid", 32'(valid_v[idx]), 32'(1));
    for (int cyc = 0; cyc < total * 4 + 100 && frames_done == fd0; cyc++) @(posedge clk);
    if (frames_done == fd0) check("frame_timeout", 32'(beat_idx), 32'(total));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    checks = 0; errors = 0; beat_idx = 0; frames_done = 0; frame_len = 0;
    done_phase = 0; stall_prev = 1'b0; stall_val = '0;
    rand_mode = 1'b0; sel = 2'd0; start = '0;
    rst_n = 1'b0;
    #2;
    check("reset_outputs",
          32'({addr_v[0], valid_v, pad_v, rd_v, last_v, busy_v, done_v}), 32'(0));
    #20;
    @(negedge clk) rst_n = 1'b1;

    run_frame(0, 3, 1, 1, 4, 2, 1'b0, 288);
    run_frame(0, 3, 1, 1, 4, 2, 1'b1, 288);
    run_frame(2, 3, 2, 0, 5, 1, 1'b0, 36);
    run_frame(1, 1, 1, 0, 26, 20, 1'b0, 13520);

    // Spurious start mid-sweep, then reset abandon and restart from beat 0.
    sel = 2'd0; beat_idx = 0; frame_len = 288; rand_mode = 1'b0;
    exp_q.delete();
    push_frame(3, 1, 1, 4, 2);
    pulse_start(0);
    wait_beats(50);
    pulse_start(0);
    check("busy_after_ignored_start", 32'(busy_v[0]), 32'(1));
    wait_beats(100);
    #2 rst_n = 1'b0;
    #1 check("reset_mid_sweep",
             32'({addr_v[0], valid_v[0], pad_v[0], rd_v[0], last_v[0], busy_v[0], done_v[0]}),
             32'(0));
    exp_q.delete();
    beat_idx = 0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_after_reset", 32'({valid_v[0], busy_v[0]}), 32'(0));
    run_frame(0, 3, 1, 1, 4, 2, 1'b0, 288);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
